bus_cycle_controller: RTL and testbench
=======================================

// Module: bus_cycle_controller
// PURPOSE
//  Parametrised 68030 async bus-cycle controller for Mackerel boards.
//  - Decodes NUM_REGIONS address regions into registered chip selects.
//  - Times per-region wait states and returns DSACK sized to the region's port width.
//  - Raises BERR via a bus watchdog.
//  - Overlays the boot region at every address for the first BOOT_CYCLES bus cycles after reset.
// PARAMETERS
//  NUM_REGIONS   4              number of decoded regions (1..8); lowest index wins on overlap
//  REGION_MATCH  32'hF0_F0_00_80  8b/region {AH[31:28],AM[19:16]} match value, region0 in LSBs
//  REGION_MASK   32'hFC_FF_F0_F0  8b/region compare mask; hit = (A & MASK)==(MATCH & MASK)
//  REGION_WAIT   16'h2_0_1_3    4b/region wait states before DSACK (0..15)
//  REGION_PORT   8'b10_01_01_01 2b/region port: 00=32b, 01=8b, 10=16b, 11=reserved (treated as 8b)
//  REGION_EXT    4'b0100        1b/region: also wait for EXT_ACK_n[i] low before DSACK
//  BOOT_CYCLES   8              bus cycles overlaid after reset (1..255)
//  BOOT_REGION   0              region selected during boot overlay
//  TIMEOUT       64             clocks from cycle start to BERR (2..1023)
// PORTS
//  CLK        in   1   CPU clock; all state updates on rising edge
//  RST_n      in   1   asynchronous active-low reset
//  AH         in   4   address bits 31:28
//  AM         in   4   address bits 19:16
//  FC         in   3   function code; 3'b111 = CPU space
//  AS_n       in   1   address strobe
//  EXT_ACK_n  in   N   per-region external ready; e.g. DUART DTACK
//  CS_n       out  N   per-region chip select, active low
//  DSACK0_n   out  1   data/size acknowledge 0
//  DSACK1_n   out  1   data/size acknowledge 1
//  BERR_n     out  1   bus error
//  BOOT       out  1   0 while the boot overlay is active
// BEHAVIOUR
//  Reset: CS_n all 1, DSACK0_n=DSACK1_n=BERR_n=1, BOOT=0, boot count=0, FSM=IDLE.
//   All are forced immediately and asynchronously, including mid-cycle.
//  FSM states: IDLE, WAIT, ACK, BERR, DONE.
//  IDLE, edge with AS_n=0:
//   - Non-CPU-space cycle: latch hit region R. R=BOOT_REGION if BOOT=0, else lowest-index hit.
//   - Assert CS_n[R]; load wait counter with REGION_WAIT[R]; clear watchdog; go to WAIT.
//   - CPU-space cycle or no hit: no CS; go to WAIT with no region (only the watchdog can end it).
//   - Boot count increments here (saturating). BOOT goes 1 on the edge where count reaches BOOT_CYCLES.
//  WAIT, per edge:
//   - Watchdog +1; wait counter -1 while nonzero.
//   - Go to ACK when counter==0 and (REGION_EXT[R]==0 or EXT_ACK_n[R]==0).
//   - Go to BERR when watchdog reaches TIMEOUT-1 (BERR wins if both conditions hold on the same edge).
//  ACK: DSACK per port width, held until AS_n sampled high.
//   - 32b: both DSACK low. 16b: DSACK1 low. 8b: DSACK0 low.
//  BERR: BERR_n=0, no DSACK, held until AS_n sampled high.
//  Any state, AS_n sampled high:
//   - Negate CS_n, DSACK, BERR on that edge; go to IDLE.
//   - An early AS_n negation (aborted cycle) in WAIT takes the same path.
//  Latency: AS_n sampled low at edge k -> CS_n low after edge k.
//   - DSACK low after edge k+WAIT+1 when EXT_ACK_n is not used.
//  Watchdog is 10b; saturates, never wraps. Wait counter never underflows.
//  Back-to-back cycles: IDLE is required for >=1 edge, so AS_n must be sampled high between cycles.
// TESTING
//  1 Reset, then 8 reads at 0x0000_0000 -> CS_n[0] each time, DSACK0 only, 4 clk after AS; 9th read -> CS_n[1], BOOT=1.
//  2 BOOT=1, read 0x0000_0004 -> CS_n[1] low, DSACK0_n low 2 clk after AS, all negated 1 edge after AS_n high.
//  3 Read 0xF010_0000 -> CS_n[3], DSACK1_n low at AS+3, DSACK0_n stays 1.
//  4 Read 0xF000_0000, EXT_ACK_n[2] held high 10 clk -> DSACK at EXT_ACK low +1; held high 70 clk -> BERR_n low at AS+64.
//  5 Read 0x4000_0000 (unmapped) and FC=7 IACK -> no CS, BERR_n low at AS+64 until AS_n high.
//  6 RST_n low during WAIT of ROM cycle -> all outputs negated async, BOOT=0, count restarts.

Source files
------------

// File: rtl/bus_cycle_controller.sv
// 68030 asynchronous bus-cycle controller: region decode to chip selects,
// per-region wait states with sized DSACK, watchdog BERR and a boot overlay.
module bus_cycle_controller #(
    parameter int unsigned                 NUM_REGIONS  = 4,
    parameter logic [8*NUM_REGIONS-1:0]    REGION_MATCH = 32'hF0_F0_00_80,
    parameter logic [8*NUM_REGIONS-1:0]    REGION_MASK  = 32'hFC_FF_F0_F0,
    parameter logic [4*NUM_REGIONS-1:0]    REGION_WAIT  = 16'h2_0_1_3,
    parameter logic [2*NUM_REGIONS-1:0]    REGION_PORT  = 8'b10_01_01_01,
    parameter logic [NUM_REGIONS-1:0]      REGION_EXT   = 4'b0100,
    parameter int unsigned                 BOOT_CYCLES  = 8,
    parameter int unsigned                 BOOT_REGION  = 0,
    parameter int unsigned                 TIMEOUT      = 64
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic [3:0]             AH,
    input  logic [3:0]             AM,
    input  logic [2:0]             FC,
    input  logic                   AS_n,
    input  logic [NUM_REGIONS-1:0] EXT_ACK_n,
    output logic [NUM_REGIONS-1:0] CS_n,
    output logic                   DSACK0_n,
    output logic                   DSACK1_n,
    output logic                   BERR_n,
    output logic                   BOOT
);

    localparam int unsigned RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BERR,
        S_DONE
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [RW-1:0]            region;
    logic                     region_vld;
    logic [3:0]               wait_cnt;
    logic [9:0]               wdog;
    logic [7:0]               boot_cnt;

    logic [7:0]               addr_key;
    logic [NUM_REGIONS-1:0]   hit;
    logic                     hit_vld;
    logic [RW-1:0]            hit_idx;
    logic                     sel_vld;
    logic [RW-1:0]            sel_idx;
    logic                     ext_ok;
    logic                     wdog_expired;

    logic [3:0]               wait_tab [NUM_REGIONS];
    logic [1:0]               port_tab [NUM_REGIONS];

    assign addr_key = {AH, AM};

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        assign wait_tab[g] = REGION_WAIT[4*g +: 4];
        assign port_tab[g] = REGION_PORT[2*g +: 2];
        assign hit[g]      = ((addr_key ^ REGION_MATCH[8*g +: 8]) & REGION_MASK[8*g +: 8]) == 8'h00;
    end

    // Lowest-index region wins when several match.
    always_comb begin
        hit_vld = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (hit[i] && !hit_vld) begin
                hit_vld = 1'b1;
                hit_idx = RW'(i);
            end
        end
    end

    assign BOOT    = (boot_cnt == 8'(BOOT_CYCLES));
    assign sel_vld = (FC != 3'b111) && (!BOOT || hit_vld);
    assign sel_idx = BOOT ? hit_idx : RW'(BOOT_REGION);

    assign ext_ok       = !REGION_EXT[region] || !EXT_ACK_n[region];
    assign wdog_expired = (wdog == 10'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!AS_n) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (AS_n) begin
                    state_nxt = S_IDLE;
                end else if (wdog_expired) begin
                    state_nxt = S_BERR;
                end else if (region_vld && wait_cnt == 4'd0 && ext_ok) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK, S_BERR, S_DONE: begin
                if (AS_n) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            region     <= '0;
            region_vld <= 1'b0;
            wait_cnt   <= '0;
            wdog       <= '0;
            boot_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!AS_n) begin
                        region     <= sel_idx;
                        region_vld <= sel_vld;
                        wait_cnt   <= sel_vld ? wait_tab[sel_idx] : 4'd0;
                        wdog       <= '0;
                        if (boot_cnt != 8'(BOOT_CYCLES)) begin
                            boot_cnt <= boot_cnt + 8'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (wdog != '1) begin
                        wdog <= wdog + 10'd1;
                    end
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Chip select stays asserted through ACK/BERR until AS_n is sampled high.
    always_comb begin
        CS_n     = '1;
        DSACK0_n = 1'b1;
        DSACK1_n = 1'b1;
        BERR_n   = 1'b1;
        if (region_vld && (state == S_WAIT || state == S_ACK || state == S_BERR)) begin
            CS_n[region] = 1'b0;
        end
        if (state == S_ACK) begin
            case (port_tab[region])
                2'b00: begin
                    DSACK0_n = 1'b0;
                    DSACK1_n = 1'b0;
                end
                2'b10:   DSACK1_n = 1'b0;
                default: DSACK0_n = 1'b0;
            endcase
        end
        if (state == S_BERR) begin
            BERR_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed and randomized bus cycles against a cycle-outcome model of the
// controller: region choice, acknowledge edge, watchdog edge and boot overlay.
module tb_bus_cycle_controller;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic [3:0] AH;
    logic [3:0] AM;
    logic [2:0] FC;
    logic       AS_n;
    logic [3:0] EXT_ACK_n;
    logic [3:0] CS_n;
    logic       DSACK0_n;
    logic       DSACK1_n;
    logic       BERR_n;
    logic       BOOT;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int boot_cnt_m = 0;

    // Board address map as documented for the default parameters.
    logic [7:0] MATCH [4] = '{8'h80, 8'h00, 8'hF0, 8'hF0};
    logic [7:0] MASK  [4] = '{8'hF0, 8'hF0, 8'hFF, 8'hFC};
    int         WAITS [4] = '{3, 1, 0, 2};
    int         WIDTH [4] = '{8, 8, 8, 16};
    bit         EXTS  [4] = '{0, 0, 1, 0};

    always #5 CLK = ~CLK;

    bus_cycle_controller dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .AH        (AH),
        .AM        (AM),
        .FC        (FC),
        .AS_n      (AS_n),
        .EXT_ACK_n (EXT_ACK_n),
        .CS_n      (CS_n),
        .DSACK0_n  (DSACK0_n),
        .DSACK1_n  (DSACK1_n),
        .BERR_n    (BERR_n),
        .BOOT      (BOOT)
    );

    function automatic logic [7:0] expv(input int region, input bit ack, input bit berr,
                                        input bit boot_o, input int width);
        logic [3:0] cs;
        logic [1:0] ds;
        cs = 4'hF;
        if (region >= 0) cs[region] = 1'b0;
        ds = 2'b11;
        if (ack) begin
            if (width == 32)      ds = 2'b00;
            else if (width == 16) ds = 2'b01;
            else                  ds = 2'b10;
        end
        return {cs, ds, ~berr, boot_o};
    endfunction

    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {CS_n, DSACK1_n, DSACK0_n, BERR_n, BOOT};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed={cs,d1,d0,berr,boot}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive_ext(input int region, input int ext_d, input int n);
        EXT_ACK_n = 4'($urandom);
        if (region >= 0 && EXTS[region]) EXT_ACK_n[region] = (n >= ext_d) ? 1'b0 : 1'b1;
    endtask

    task automatic do_reset(input string tag);
        RST_n = 1'b0;
        AS_n  = 1'b1;
        boot_cnt_m = 0;
        #1;
        check({tag, "_async"}, expv(-1, 0, 0, 0, 8));
        repeat (2) @(negedge CLK);
        check({tag, "_held"}, expv(-1, 0, 0, 0, 8));
        RST_n = 1'b1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            AH = 4'($urandom);
            AM = 4'($urandom);
            EXT_ACK_n = 4'($urandom);
            @(negedge CLK);
            check($sformatf("idle_c%0d", cyc), expv(-1, 0, 0, boot_cnt_m >= 8, 8));
        end
    endtask

    // One bus cycle starting at a negedge. AS_n is sampled low at edges 0..hold
    // and high at edge hold+1; hold<0 means hold a few edges past the outcome.
    task automatic run_cycle(input logic [3:0] ah, input logic [3:0] am, input logic [2:0] fc,
                             input int ext_d, input int hold, input int rst_at);
        int  region;
        int  e;
        int  w;
        int  L;
        int  width;
        bit  berr_case;
        region = -1;
        if (fc != 3'b111) begin
            if (boot_cnt_m < 8) region = 0;
            else for (int i = 3; i >= 0; i--)
                if (({ah, am} & MASK[i]) == (MATCH[i] & MASK[i])) region = i;
        end
        boot_cnt_m = (boot_cnt_m < 8) ? boot_cnt_m + 1 : 8;
        e = 64;
        berr_case = 1'b1;
        if (region >= 0) begin
            w = WAITS[region] + 1;
            if (EXTS[region] && ext_d > w) w = ext_d;
            if (w < 64) begin
                e = w;
                berr_case = 1'b0;
            end
        end
        L = (hold >= 0) ? hold : e + int'($urandom_range(0, 3));
        width = (region >= 0) ? WIDTH[region] : 8;
        AH = ah;
        AM = am;
        FC = fc;
        AS_n = 1'b0;
        drive_ext(region, ext_d, 0);
        for (int n = 0; n <= L + 1; n++) begin
            @(negedge CLK);
            if (n <= L)
                check($sformatf("c%0d_n%0d", cyc, n),
                      expv(region, !berr_case && n >= e, berr_case && n >= e, boot_cnt_m >= 8, width));
            else
                check($sformatf("c%0d_end", cyc), expv(-1, 0, 0, boot_cnt_m >= 8, 8));
            if (n == rst_at) begin
                do_reset($sformatf("c%0d_rst", cyc));
                cyc++;
                return;
            end
            AS_n = (n + 1 <= L) ? 1'b0 : 1'b1;
            drive_ext(region, ext_d, n + 1);
        end
        cyc++;
    endtask

    initial begin
        int kind;
        logic [3:0] ah;
        logic [3:0] am;
        logic [2:0] fc;
        int ext_d;
        int hold;

        RST_n = 1'b0;
        AS_n = 1'b1;
        AH = '0;
        AM = '0;
        FC = 3'd5;
        EXT_ACK_n = '1;
        #1;
        check("reset", expv(-1, 0, 0, 0, 8));
        repeat (2) @(negedge CLK);
        check("reset_held", expv(-1, 0, 0, 0, 8));
        RST_n = 1'b1;
        idle(1);

        // Boot overlay: eight cycles at 0x0 land on the ROM, the ninth on RAM.
        for (int i = 0; i < 9; i++) begin
            run_cycle(4'h0, 4'h0, 3'd5, 1, -1, -1);
            idle(1);
        end
        run_cycle(4'h0, 4'h0, 3'd5, 1, 2, -1);
        idle(2);
        run_cycle(4'hF, 4'h1, 3'd5, 1, -1, -1);
        idle(1);
        run_cycle(4'hF, 4'h0, 3'd5, 10, -1, -1);
        idle(1);
        run_cycle(4'hF, 4'h0, 3'd5, 70, -1, -1);
        idle(1);
        run_cycle(4'h4, 4'h0, 3'd5, 1, -1, -1);
        idle(1);
        run_cycle(4'h0, 4'h0, 3'd7, 1, 66, -1);
        idle(1);
        run_cycle(4'h8, 4'h0, 3'd5, 1, 1, -1);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 5));
            ah = 4'($urandom);
            am = 4'($urandom);
            case (kind)
                0: ah = 4'h8;
                1: ah = 4'h0;
                2: begin ah = 4'hF; am = 4'h0; end
                3: begin ah = 4'hF; am = 4'($urandom_range(1, 3)); end
                4: ah = 4'($urandom_range(1, 7));
                default: ;
            endcase
            fc = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(1, 6));
            ext_d = ($urandom_range(0, 7) == 0) ? 80 : int'($urandom_range(1, 20));
            hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_cycle(ah, am, fc, ext_d, hold, -1);
            idle(int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a ROM wait, then the overlay starts over.
        run_cycle(4'h8, 4'h0, 3'd5, 1, -1, 1);
        idle(1);
        run_cycle(4'h0, 4'h0, 3'd5, 1, -1, -1);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
